// File: rtl/bm_pixel_reorder.sv
// Reorders per-ray colour results into strict rayID order for the frame writer,
// converting float RGB to 8-bit. Define BM_FRAME_CNT_EN to add frame_done/frame_cnt outputs.
module bm_pixel_reorder #(
    parameter int ID_W     = 9,
    parameter int NUM_RAYS = 512
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 calc_direct_to_BM_valid,
    input  logic [ID_W+95:0]     calc_direct_to_BM_data,
    output logic                 calc_direct_to_BM_stall,
    output logic                 pixel_valid,
    output logic [ID_W+23:0]     pixel_data,
    input  logic                 pixel_stall
`ifdef BM_FRAME_CNT_EN
    ,
    output logic                 frame_done,
    output logic [15:0]          frame_cnt
`endif
);

    // Input word is {rayID, R, G, B}, each channel an IEEE-754 single.
    function automatic logic [7:0] to_u8(input logic [31:0] f);
        logic [7:0]  e;
        logic [7:0]  sh;
        logic [23:0] m;
        e  = f[30:23];
        sh = 8'd142 - e;
        m  = {1'b1, f[22:0]} >> sh;
        if (f[31] || e == 8'd0 || (e == 8'hFF && f[22:0] != 23'd0))
            return 8'd0;
        else if (e >= 8'd127)
            return 8'hFF;
        else if (sh >= 8'd24)
            return 8'd0;
        else if (m[23:8] != 16'd0)
            return 8'hFF;
        else
            return m[7:0];
    endfunction

    logic [ID_W-1:0]     wr_id;
    logic [23:0]         wr_rgb;
    logic [23:0]         mem [NUM_RAYS];
    logic [NUM_RAYS-1:0] vbit;
    logic [ID_W-1:0]     rd_ptr;
    logic                accept;
    logic                load;

    assign wr_id  = calc_direct_to_BM_data[ID_W+95:96];
    assign wr_rgb = {to_u8(calc_direct_to_BM_data[95:64]),
                     to_u8(calc_direct_to_BM_data[63:32]),
                     to_u8(calc_direct_to_BM_data[31:0])};

    // An occupied slot holds a ray not yet drained; the writer waits rather than overwrite it.
    assign calc_direct_to_BM_stall = calc_direct_to_BM_valid && vbit[wr_id];
    assign accept = calc_direct_to_BM_valid && !vbit[wr_id];
    assign load   = vbit[rd_ptr] && (!pixel_valid || !pixel_stall);

    always_ff @(posedge clk) begin
        if (accept)
            mem[wr_id] <= wr_rgb;
    end

    // Write and drain never touch the same slot in one cycle: the stall rule forbids it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vbit        <= '0;
            rd_ptr      <= '0;
            pixel_valid <= 1'b0;
            pixel_data  <= '0;
        end else begin
            if (accept)
                vbit[wr_id] <= 1'b1;
            if (load) begin
                vbit[rd_ptr] <= 1'b0;
                rd_ptr       <= (rd_ptr == ID_W'(NUM_RAYS - 1)) ? '0 : rd_ptr + 1'b1;
                pixel_valid  <= 1'b1;
                pixel_data   <= {rd_ptr, mem[rd_ptr]};
            end else if (!pixel_stall) begin
                pixel_valid  <= 1'b0;
            end
        end
    end

`ifdef BM_FRAME_CNT_EN
    assign frame_done = pixel_valid && !pixel_stall &&
                        (pixel_data[ID_W+23:24] == ID_W'(NUM_RAYS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            frame_cnt <= 16'd0;
        else if (frame_done)
            frame_cnt <= frame_cnt + 16'd1;
    end
`endif

endmodule
